// File: rtl/img_pkg.sv
// Shared image-pipeline constants, legal window configurations and width helpers.
package img_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_ROW   = 480;
  localparam int unsigned DEF_COL   = 752;

  localparam int unsigned KSIZE_SMALL = 2;
  localparam int unsigned KSIZE_LARGE = 4;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit legal_ksize(input int unsigned k);
    return (k == KSIZE_SMALL) || (k == KSIZE_LARGE);
  endfunction

  function automatic bit legal_decim(input int unsigned d, input int unsigned k);
    return (d == 1) || (d == k);
  endfunction

endpackage

// File: rtl/box_sum_tree.sv
// Combinational unsigned sum of NPIX packed pixels into a no-overflow accumulator.
module box_sum_tree #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NPIX  = 4,
  parameter int unsigned SW    = 10
) (
  input  logic [NPIX*WIDTH-1:0] pix,
  output logic [SW-1:0]         sum_c
);

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(NPIX); i++) begin
      sum_c = sum_c + SW'(pix[i*WIDTH +: WIDTH]);
    end
  end

endmodule

// File: rtl/box_avg_kernel.sv
// KSIZE x KSIZE box filter: position tracking, column-shift window, registered sum and mean.
// Define BOX_AVG_ROUND_EN for round-half-up on dout; otherwise dout truncates.
module box_avg_kernel
  import img_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned KSIZE = 2,
  parameter int unsigned DECIM = 1,
  parameter int unsigned ROW   = DEF_ROW,
  parameter int unsigned COL   = DEF_COL
) (
  input  logic                             clk,
  input  logic                             en,
  input  logic                             in_valid,
  input  logic                             in_sof,
  input  logic [KSIZE*WIDTH-1:0]           din,
  output logic [WIDTH-1:0]                 dout,
  output logic [WIDTH+2*clog2(KSIZE)-1:0]  dout_sum,
  output logic                             out_valid,
  output logic                             out_sof,
  output logic                             out_eol
);

  localparam int unsigned LOGK = clog2(KSIZE);
  localparam int unsigned SH   = 2 * LOGK;
  localparam int unsigned SW   = WIDTH + SH;
  localparam int unsigned NPIX = KSIZE * KSIZE;
  localparam int unsigned CW   = (clog2(COL) > 0) ? clog2(COL) : 1;
  localparam int unsigned RW   = (clog2(ROW) > 0) ? clog2(ROW) : 1;
  localparam bit          TILE = (DECIM == KSIZE);

  if (!legal_ksize(KSIZE)) begin : g_bad_ksize
    $error("box_avg_kernel: KSIZE must be 2 or 4");
  end
  if (!legal_decim(DECIM, KSIZE)) begin : g_bad_decim
    $error("box_avg_kernel: DECIM must be 1 or KSIZE");
  end

  logic [CW-1:0] col_cnt, cur_col_c, nxt_col_c;
  logic [RW-1:0] row_cnt, cur_row_c, nxt_row_c;
  logic          elig_c, first_c, last_c;

  logic                   s0_valid, s0_elig, s0_sof, s0_eol;
  logic [KSIZE*WIDTH-1:0] s0_din;
  logic [WIDTH-1:0]       win [KSIZE][KSIZE];
  logic                   s1_elig, s1_sof, s1_eol;
  logic [NPIX*WIDTH-1:0]  win_flat_c;
  logic [SW-1:0]          sum_c;
  logic [WIDTH-1:0]       mean_c;

  // Position of the pixel on the bus; in_sof forces (0,0) at any point in the frame.
  always_comb begin
    cur_col_c = in_sof ? '0 : col_cnt;
    cur_row_c = in_sof ? '0 : row_cnt;
    nxt_col_c = cur_col_c + CW'(1);
    nxt_row_c = cur_row_c;
    if (cur_col_c == CW'(COL - 1)) begin
      nxt_col_c = '0;
      nxt_row_c = (cur_row_c == RW'(ROW - 1)) ? '0 : cur_row_c + RW'(1);
    end
    elig_c = (cur_col_c >= CW'(KSIZE - 1)) && (cur_row_c >= RW'(KSIZE - 1));
    if (TILE) begin
      elig_c = elig_c && ((cur_col_c & CW'(KSIZE - 1)) == CW'(KSIZE - 1))
                      && ((cur_row_c & RW'(KSIZE - 1)) == RW'(KSIZE - 1));
    end
    first_c = (cur_col_c == CW'(KSIZE - 1)) && (cur_row_c == RW'(KSIZE - 1));
    last_c  = (cur_col_c == CW'(COL - 1));
  end

  always_ff @(posedge clk or negedge en) begin
    if (!en) begin
      col_cnt  <= '0;
      row_cnt  <= '0;
      s0_valid <= 1'b0;
      s0_elig  <= 1'b0;
      s0_sof   <= 1'b0;
      s0_eol   <= 1'b0;
      s0_din   <= '0;
    end else begin
      s0_valid <= in_valid;
      s0_elig  <= in_valid && elig_c;
      s0_sof   <= in_valid && elig_c && first_c;
      s0_eol   <= in_valid && elig_c && last_c;
      if (in_valid) begin
        col_cnt <= nxt_col_c;
        row_cnt <= nxt_row_c;
        s0_din  <= din;
      end
    end
  end

  // Window: column KSIZE-1 is the newest, shifts only on accepted pixels.
  always_ff @(posedge clk or negedge en) begin
    if (!en) begin
      for (int k = 0; k < int'(KSIZE); k++) begin
        for (int j = 0; j < int'(KSIZE); j++) begin
          win[k][j] <= '0;
        end
      end
      s1_elig <= 1'b0;
      s1_sof  <= 1'b0;
      s1_eol  <= 1'b0;
    end else begin
      if (s0_valid) begin
        for (int k = 0; k < int'(KSIZE); k++) begin
          for (int j = 0; j < int'(KSIZE) - 1; j++) begin
            win[k][j] <= win[k][j+1];
          end
          win[k][KSIZE-1] <= s0_din[k*WIDTH +: WIDTH];
        end
      end
      s1_elig <= s0_elig;
      s1_sof  <= s0_sof;
      s1_eol  <= s0_eol;
    end
  end

  always_comb begin
    win_flat_c = '0;
    for (int k = 0; k < int'(KSIZE); k++) begin
      for (int j = 0; j < int'(KSIZE); j++) begin
        win_flat_c[(k*KSIZE + j)*WIDTH +: WIDTH] = win[k][j];
      end
    end
  end

  box_sum_tree #(
    .WIDTH (WIDTH),
    .NPIX  (NPIX),
    .SW    (SW)
  ) u_sum_tree (
    .pix   (win_flat_c),
    .sum_c (sum_c)
  );

`ifdef BOX_AVG_ROUND_EN
  localparam int unsigned HALF = 2 ** (SH - 1);
  logic [SW:0] rnd_c;
  assign rnd_c  = {1'b0, sum_c} + (SW+1)'(HALF);
  assign mean_c = WIDTH'(rnd_c >> SH);
`else
  assign mean_c = WIDTH'(sum_c >> SH);
`endif

  // Result registers hold their value across bubbles and ineligible windows.
  always_ff @(posedge clk or negedge en) begin
    if (!en) begin
      dout      <= '0;
      dout_sum  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else begin
      out_valid <= s1_elig;
      out_sof   <= s1_sof;
      out_eol   <= s1_eol;
      if (s1_elig) begin
        dout_sum <= sum_c;
        dout     <= mean_c;
      end
    end
  end

endmodule

// File: tb/tb_box_avg_kernel.sv
// Randomized bench for box_avg_kernel: three configurations against a frame-level reference model.
module tb_box_avg_kernel;

  localparam int COL = 8;
  localparam int ROW = 4;
  localparam int NI  = 3;

  logic        clk = 1'b0;
  logic        en;
  logic        in_valid;
  logic        in_sof;
  logic [15:0] din2;
  logic [31:0] din4;

  logic [7:0]  dout_a, dout_b, dout_c;
  logic [9:0]  sum_a, sum_b;
  logic [11:0] sum_c;
  logic        v_a, v_b, v_c, sof_a, sof_b, sof_c, eol_a, eol_b, eol_c;

  logic        ov   [NI];
  logic        osof [NI];
  logic        oeol [NI];
  logic [7:0]  odout[NI];
  logic [11:0] osum [NI];

  always #5 clk = ~clk;

  box_avg_kernel #(.WIDTH(8), .KSIZE(2), .DECIM(1), .ROW(ROW), .COL(COL)) u_s2 (
    .clk(clk), .en(en), .in_valid(in_valid), .in_sof(in_sof), .din(din2),
    .dout(dout_a), .dout_sum(sum_a), .out_valid(v_a), .out_sof(sof_a), .out_eol(eol_a));

  box_avg_kernel #(.WIDTH(8), .KSIZE(2), .DECIM(2), .ROW(ROW), .COL(COL)) u_t2 (
    .clk(clk), .en(en), .in_valid(in_valid), .in_sof(in_sof), .din(din2),
    .dout(dout_b), .dout_sum(sum_b), .out_valid(v_b), .out_sof(sof_b), .out_eol(eol_b));

  box_avg_kernel #(.WIDTH(8), .KSIZE(4), .DECIM(1), .ROW(ROW), .COL(COL)) u_s4 (
    .clk(clk), .en(en), .in_valid(in_valid), .in_sof(in_sof), .din(din4),
    .dout(dout_c), .dout_sum(sum_c), .out_valid(v_c), .out_sof(sof_c), .out_eol(eol_c));

  assign ov[0] = v_a;   assign ov[1] = v_b;   assign ov[2] = v_c;
  assign osof[0] = sof_a; assign osof[1] = sof_b; assign osof[2] = sof_c;
  assign oeol[0] = eol_a; assign oeol[1] = eol_b; assign oeol[2] = eol_c;
  assign odout[0] = dout_a; assign odout[1] = dout_b; assign odout[2] = dout_c;
  assign osum[0] = 12'(sum_a); assign osum[1] = 12'(sum_b); assign osum[2] = sum_c;

  typedef struct {
    bit v;
    bit sof;
    bit eol;
    int sum;
    int mean;
  } rec_t;

  int   img [ROW][COL];
  rec_t hist [NI][3];
  int   hold_sum [NI];
  int   hold_mean[NI];
  int   vcount   [NI];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic int ksz(input int i);
    return (i == 2) ? 4 : 2;
  endfunction

  function automatic int dec(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  // Expected output for the window ending at pixel (r,c), straight from the frame image.
  function automatic rec_t model(input int i, input bit v, input int r, input int c);
    rec_t e;
    int   k, sh;
    k = ksz(i);
    sh = (k == 4) ? 4 : 2;
    e.v = 0; e.sof = 0; e.eol = 0; e.sum = 0; e.mean = 0;
    if (v && r >= k-1 && c >= k-1 && (dec(i) == 1 || (r % k == k-1 && c % k == k-1))) begin
      e.v = 1;
      for (int y = r-k+1; y <= r; y++)
        for (int x = c-k+1; x <= c; x++)
          e.sum += img[y][x];
`ifdef BOX_AVG_ROUND_EN
      e.mean = (e.sum + (1 << (sh-1))) >> sh;
`else
      e.mean = e.sum >> sh;
`endif
      e.sof = (r == k-1) && (c == k-1);
      e.eol = (c == COL-1);
    end
    return e;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NI; i++) begin
      for (int j = 0; j < 3; j++) hist[i][j] = model(i, 1'b0, 0, 0);
      hold_sum[i] = 0;
      hold_mean[i] = 0;
    end
  endtask

  task automatic fill_const(input int val);
    for (int r = 0; r < ROW; r++)
      for (int c = 0; c < COL; c++) img[r][c] = val;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < ROW; r++)
      for (int c = 0; c < COL; c++) img[r][c] = int'($urandom_range(0, 255));
  endtask

  // One clock: drive at negedge, then compare every instance just after the rising edge.
  task automatic step(input bit v, input bit sof, input int r, input int c);
    rec_t e;
    @(negedge clk);
    in_valid = v;
    in_sof   = sof;
    for (int k = 0; k < 2; k++)
      din2[k*8 +: 8] = (v && r-1+k >= 0) ? 8'(img[r-1+k][c]) : 8'($urandom);
    for (int k = 0; k < 4; k++)
      din4[k*8 +: 8] = (v && r-3+k >= 0) ? 8'(img[r-3+k][c]) : 8'($urandom);
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      hist[i][2] = hist[i][1];
      hist[i][1] = hist[i][0];
      hist[i][0] = model(i, v, r, c);
      e = hist[i][2];
      if (e.v) begin
        hold_sum[i]  = e.sum;
        hold_mean[i] = e.mean;
      end
      n_checks++;
      if (ov[i] !== e.v) $display("FAIL out_valid inst%0d t=%0t: got %b want %b", i, $time, ov[i], e.v);
      else n_pass++;
      n_checks++;
      if (osof[i] !== e.sof) $display("FAIL out_sof inst%0d t=%0t: got %b want %b", i, $time, osof[i], e.sof);
      else n_pass++;
      n_checks++;
      if (oeol[i] !== e.eol) $display("FAIL out_eol inst%0d t=%0t: got %b want %b", i, $time, oeol[i], e.eol);
      else n_pass++;
      n_checks++;
      if (osum[i] !== 12'(hold_sum[i])) $display("FAIL dout_sum inst%0d t=%0t: got %0d want %0d", i, $time, osum[i], hold_sum[i]);
      else n_pass++;
      n_checks++;
      if (odout[i] !== 8'(hold_mean[i])) $display("FAIL dout inst%0d t=%0t: got %0d want %0d", i, $time, odout[i], hold_mean[i]);
      else n_pass++;
      if (ov[i] === 1'b1) vcount[i]++;
    end
  endtask

  // Raster scan of npix pixels from (0,0); gap 0 none, 1 alternating, 2 random bubbles.
  task automatic run_pixels(input bit sof_first, input int gap, input int npix);
    for (int idx = 0; idx < npix; idx++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) step(1'b0, 1'b0, 0, 0);
      step(1'b1, sof_first && idx == 0, idx / COL, idx % COL);
    end
  endtask

  task automatic flush();
    repeat (3) step(1'b0, 1'b0, 0, 0);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NI; i++) vcount[i] = 0;
  endtask

  task automatic test_reset();
    en = 1'b0; in_valid = 1'b0; in_sof = 1'b0; din2 = '0; din4 = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if ({ov[i], osof[i], oeol[i]} !== 3'b000) $display("FAIL reset_flags inst%0d: got %b%b%b want 000", i, ov[i], osof[i], oeol[i]);
      else n_pass++;
      n_checks++;
      if (osum[i] !== 12'd0 || odout[i] !== 8'd0) $display("FAIL reset_data inst%0d: got %0d/%0d want 0/0", i, osum[i], odout[i]);
      else n_pass++;
    end
    @(negedge clk);
    en = 1'b1;
  endtask

  task automatic test_const_frame();
    fill_const(100);
    clear_counts();
    run_pixels(1'b1, 0, ROW*COL);
    flush();
    n_checks++;
    if (vcount[0] !== 21) $display("FAIL count_sliding: got %0d want 21", vcount[0]); else n_pass++;
    n_checks++;
    if (vcount[1] !== 8) $display("FAIL count_tiled: got %0d want 8", vcount[1]); else n_pass++;
    n_checks++;
    if (vcount[2] !== 5) $display("FAIL count_k4: got %0d want 5", vcount[2]); else n_pass++;
    n_checks++;
    if (osum[0] !== 12'd400 || odout[0] !== 8'd100) $display("FAIL const_k2: got %0d/%0d want 400/100", osum[0], odout[0]);
    else n_pass++;
  endtask

  task automatic test_known_window();
    fill_rand();
    img[0][0] = 1; img[0][1] = 2; img[1][0] = 3; img[1][1] = 4;
    run_pixels(1'b1, 0, COL + 2);
    flush();
  endtask

  task automatic test_max_value();
    fill_const(255);
    run_pixels(1'b1, 0, ROW*COL);
    flush();
    n_checks++;
    if (osum[2] !== 12'd4080 || odout[2] !== 8'd255) $display("FAIL max_k4: got %0d/%0d want 4080/255", osum[2], odout[2]);
    else n_pass++;
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++) begin
      fill_rand();
      run_pixels(f == 0, 0, ROW*COL);
    end
    flush();
  endtask

  task automatic test_gaps();
    fill_rand();
    clear_counts();
    run_pixels(1'b1, 1, ROW*COL);
    flush();
    n_checks++;
    if (vcount[0] !== 21) $display("FAIL count_gaps: got %0d want 21", vcount[0]); else n_pass++;
    fill_rand();
    run_pixels(1'b1, 2, ROW*COL);
    flush();
  endtask

  task automatic test_sof_midframe();
    fill_rand();
    run_pixels(1'b1, 0, 13 + int'($urandom_range(0, 10)));
    fill_rand();
    run_pixels(1'b1, 0, ROW*COL);
    flush();
  endtask

  task automatic test_reset_midframe();
    fill_rand();
    run_pixels(1'b1, 0, 2*COL + 4);
    @(negedge clk);
    in_valid = 1'b0;
    in_sof = 1'b0;
    #2 en = 1'b0;
    #1;
    clear_model();
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if ({ov[i], osof[i], oeol[i]} !== 3'b000 || osum[i] !== 12'd0 || odout[i] !== 8'd0)
        $display("FAIL midframe_reset inst%0d: got %b%b%b %0d/%0d want 000 0/0", i, ov[i], osof[i], oeol[i], osum[i], odout[i]);
      else n_pass++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    en = 1'b1;
    flush();
    fill_rand();
    clear_counts();
    run_pixels(1'b0, 0, ROW*COL);
    flush();
    n_checks++;
    if (vcount[0] !== 21) $display("FAIL count_after_reset: got %0d want 21", vcount[0]); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_const_frame();
    test_known_window();
    test_max_value();
    test_random_frames();
    test_gaps();
    test_sof_midframe();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/box_avg_kernel.md
BOX_AVG_KERNEL -- requirements
Module: box_avg_kernel

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning bits per pixel.
REQ-002 The block SHALL have parameter KSIZE, default 2, meaning window edge length; legal values are 2 and 4.
REQ-003 The block SHALL have parameter DECIM, default 1, meaning output stride; legal values are 1 (sliding window) and KSIZE (non-overlapping tiles).
REQ-004 The block SHALL have parameter ROW, default 480, meaning frame height in lines.
REQ-005 The block SHALL have parameter COL, default 752, meaning frame width in pixels.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port en, input, 1 bit: asynchronous reset, active-low.
REQ-008 The block SHALL have port in_valid, input, 1 bit: one pixel column per cycle when high.
REQ-009 The block SHALL have port in_sof, input, 1 bit: start of frame; qualified by in_valid.
REQ-010 The block SHALL have port din, input, KSIZE*WIDTH bits: line taps; slice 0 is the oldest line and slice KSIZE-1 is the current line.
REQ-011 The block SHALL have port dout, output, WIDTH bits: window mean.
REQ-012 The block SHALL have port dout_sum, output, WIDTH+2*log2(KSIZE) bits: raw window sum.
REQ-013 The block SHALL have port out_valid, output, 1 bit: dout and dout_sum are valid.
REQ-014 The block SHALL have port out_sof, output, 1 bit: first output of the frame.
REQ-015 The block SHALL have port out_eol, output, 1 bit: last output of an output line.

Function
REQ-016 The block SHALL keep internal col_cnt in 0..COL-1 and row_cnt in 0..ROW-1, advancing only on in_valid.
REQ-017 col_cnt SHALL wrap from COL-1 to 0 and increment row_cnt at the same time; row_cnt SHALL wrap from ROW-1 to 0.
REQ-018 When in_valid and in_sof are both high, the current pixel SHALL be taken as (row 0, col 0), overriding the counters, including mid-frame.
REQ-019 The window SHALL be a KSIZE x KSIZE register array that shifts one column per accepted pixel; the new column is loaded from din.
REQ-020 A window SHALL be eligible only when col_cnt >= KSIZE-1 and row_cnt >= KSIZE-1, so stale columns from the previous line are never summed.
REQ-021 With DECIM=KSIZE, a window SHALL additionally require the low log2(KSIZE) bits of both col_cnt and row_cnt to be all ones.
REQ-022 dout_sum SHALL be the exact unsigned sum of the KSIZE^2 pixels, with no overflow possible.
REQ-023 dout SHALL be dout_sum shifted right by 2*log2(KSIZE) bits (see REQ-033 for rounding).
REQ-024 Latency SHALL be 2 cycles: the window is registered at t+1 and the sum/outputs at t+2 after the accepting edge t.
REQ-025 There is no backpressure; when in_valid is low, the pipeline SHALL insert a bubble with out_valid low.
REQ-026 out_sof SHALL be high with the first eligible window of the frame.
REQ-027 out_eol SHALL be high with the eligible window at col_cnt=COL-1.
REQ-028 dout and dout_sum SHALL hold their last value while out_valid is low.

Reset
REQ-029 While en is low, the counters, all window registers, dout, dout_sum, out_valid, out_sof and out_eol SHALL be 0 immediately, asynchronously.
REQ-030 After en rises, the first in_valid pixel SHALL be (row 0, col 0) whether or not in_sof is high.
REQ-031 Reset asserted mid-frame SHALL discard all in-flight windows; no out_valid pulse SHALL follow release without fresh input.

Configuration
REQ-032 Rounding SHALL be controlled by macro BOX_AVG_ROUND_EN.
REQ-033 With BOX_AVG_ROUND_EN defined, dout SHALL be (dout_sum + 2^(2*log2(KSIZE)-1)) >> 2*log2(KSIZE), i.e. round half up; the result cannot exceed 2^WIDTH-1.
REQ-034 With BOX_AVG_ROUND_EN undefined, dout SHALL be the truncated shift; dout_sum SHALL be unchanged in both cases.

Structure
REQ-035 Package img_pkg SHALL hold the default WIDTH/ROW/COL constants, the legal KSIZE/DECIM values and a clog2 helper used for width derivation.
REQ-036 The block SHALL instantiate sub-module box_sum_tree: a combinational KSIZE^2-input unsigned adder tree; the output register stays in box_avg_kernel.
REQ-037 Illegal KSIZE or DECIM values SHALL stop elaboration with an error.

Verification
REQ-038 KSIZE=2, COL=8, ROW=4, all pixels 100 -> dout 100, dout_sum 400, 7 outputs per line on rows 1..3, first out_valid 2 cycles after pixel (1,1).
REQ-039 KSIZE=2, window {1,2,3,4} -> dout_sum 10; dout 2 without BOX_AVG_ROUND_EN, 3 with it.
REQ-040 KSIZE=4, all pixels 255 -> dout_sum 4080, dout 255 in both rounding modes.
REQ-041 KSIZE=2, DECIM=2, COL=8, ROW=4 -> outputs only on rows 1 and 3 at cols 1,3,5,7; 8 per frame; out_eol at col 7; out_sof once.
REQ-042 in_valid toggling 1/0 -> outputs identical to the gap-free run, each 2 cycles after its completing pixel, with out_valid low in the gaps.
REQ-043 en low at (2,3), then released -> all outputs 0 immediately; the next pixel is treated as (0,0); no out_valid until (1,1) is reached again.
